// File: rtl/dfi_modport_pkg.sv
// ---------------------------------------------------------------------------
// dfi_modport_pkg
// Shared constants, the rule-index enum and the address-busy helper used by
// the DFI control-channel protocol checker.
// ---------------------------------------------------------------------------
package dfi_modport_pkg;

  localparam int ERR_W            = 12;
  localparam int NUM_PHASES       = 4;
  localparam int ADDR_W           = 14;
  localparam int DEF_TLP_RESP     = 8;
  localparam int DEF_TPHYUPD_RESP = 16;

  // Bit positions within err_pulse / err_sticky
  typedef enum logic [3:0] {
    LP_CTRL_TO      = 4'd0,
    LP_DATA_TO      = 4'd1,
    LP_CTRL_ACKDROP = 4'd2,
    LP_DATA_ACKDROP = 4'd3,
    PHYUPD_TO       = 4'd4,
    PHYUPD_REREQ    = 4'd5,
    PHYUPD_ACKHOLD  = 4'd6,
    FORBIDDEN       = 4'd7,
    PHYUPD_NOTIDLE  = 4'd8,
    CTRLUPD_NOTIDLE = 4'd9,
    LPDATA_BUSY     = 4'd10,
    LPCTRL_BUSY     = 4'd11
  } rule_e;

  // A cycle counts as address-busy when any phase carries the active code.
  function automatic logic addr_busy(input logic [NUM_PHASES*ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0]            code);
    logic busy;
    busy = 1'b0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (addr[p*ADDR_W +: ADDR_W] == code) busy = 1'b1;
    end
    return busy;
  endfunction

endpackage

// File: rtl/dfi_modport_if.sv
// ---------------------------------------------------------------------------
// dfi_modport_if
// DFI control-channel signal bundle as seen at the MC-PHY boundary.
//   master : drives every signal (memory controller / PHY side, or a bench)
//   slave  : observes every signal (the protocol checker)
// Signals: ctrlupd_req/ack, phyupd_req/ack, phymstr_req/ack,
//          lp_ctrl_req/ack, lp_data_req/ack, init_start,
//          address[55:0] (4 phases x 14 b), wrdata_en[3:0], rddata_en[3:0]
// ---------------------------------------------------------------------------
interface dfi_modport_if;
  import dfi_modport_pkg::*;

  logic                         ctrlupd_req;
  logic                         ctrlupd_ack;
  logic                         phyupd_req;
  logic                         phyupd_ack;
  logic                         phymstr_req;
  logic                         phymstr_ack;
  logic                         lp_ctrl_req;
  logic                         lp_ctrl_ack;
  logic                         lp_data_req;
  logic                         lp_data_ack;
  logic                         init_start;
  logic [NUM_PHASES*ADDR_W-1:0] address;
  logic [NUM_PHASES-1:0]        wrdata_en;
  logic [NUM_PHASES-1:0]        rddata_en;

  modport master (
    output ctrlupd_req, ctrlupd_ack, phyupd_req, phyupd_ack,
           phymstr_req, phymstr_ack, lp_ctrl_req, lp_ctrl_ack,
           lp_data_req, lp_data_ack, init_start, address,
           wrdata_en, rddata_en
  );

  modport slave (
    input  ctrlupd_req, ctrlupd_ack, phyupd_req, phyupd_ack,
           phymstr_req, phymstr_ack, lp_ctrl_req, lp_ctrl_ack,
           lp_data_req, lp_data_ack, init_start, address,
           wrdata_en, rddata_en
  );

endinterface

// File: rtl/dfi_modport_req_timeout.sv
// ---------------------------------------------------------------------------
// dfi_req_timeout
// Counts consecutive samples with cond=1, saturating at LIMIT; any sample
// with cond=0 clears it. expired is high while the count holds LIMIT, i.e.
// the previous LIMIT samples all had cond=1.
// Ports: clock, reset (async active-low), cond (in), expired (out)
// ---------------------------------------------------------------------------
module dfi_req_timeout #(
  parameter int LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic cond,
  output logic expired
);

  localparam int             CW  = $clog2(LIMIT + 1);
  localparam logic [CW-1:0]  LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (cond) begin
      cnt_d = (cnt_q == LIM) ? LIM : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIM);

endmodule

// File: rtl/dfi_modport.sv
// ---------------------------------------------------------------------------
// dfi_modport
// Passive DFI control-channel protocol checker. Watches update, PHY-master,
// low-power and init handshakes and flags timeout, ack-drop, forbidden
// overlap and idle-requirement violations. Never drives DFI.
// Ports:
//   clock       in   sampling clock (posedge)
//   reset       in   async active-low reset
//   dfi         in   dfi_modport_if.slave monitor view
//   err_clr     in   sync clear of err_sticky / err_count
//   err_pulse   out  [11:0] per-rule violation, one cycle, 1 clk latency
//   err_sticky  out  [11:0] accumulated err_pulse
//   err_any     out  OR of err_pulse
//   err_count   out  [CNT_W-1:0] saturating count of err_any cycles
// Build option: define DFI_MODPORT_SVA_EN to add per-rule concurrent
// assertions and X checks on the inputs; flag behaviour is unchanged.
// ---------------------------------------------------------------------------
module dfi_modport
  import dfi_modport_pkg::*;
#(
  parameter int                TLP_RESP     = DEF_TLP_RESP,
  parameter int                TPHYUPD_RESP = DEF_TPHYUPD_RESP,
  parameter logic [ADDR_W-1:0] ACTIVE_CODE  = 14'h0001,
  parameter int                CNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  dfi_modport_if.slave       dfi,
  input  logic               err_clr,
  output logic [ERR_W-1:0]   err_pulse,
  output logic [ERR_W-1:0]   err_sticky,
  output logic               err_any,
  output logic [CNT_W-1:0]   err_count
);

  logic lp_ctrl_wait, lp_data_wait, phyupd_wait;
  logic lp_ctrl_exp, lp_data_exp, phyupd_exp;
  logic busy;
  logic forbidden;

  logic lp_ctrl_ack_q, lp_ctrl_ack_d;
  logic lp_data_ack_q, lp_data_ack_d;
  logic phyupd_req_q, phyupd_req_d;

  logic [ERR_W-1:0] pulse_q, pulse_d;
  logic [ERR_W-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign lp_ctrl_wait = dfi.lp_ctrl_req & ~dfi.lp_ctrl_ack;
  assign lp_data_wait = dfi.lp_data_req & ~dfi.lp_data_ack;
  assign phyupd_wait  = dfi.phyupd_req  & ~dfi.phyupd_ack;

  // The lp counters only need LIMIT samples of history; the "still
  // requesting" qualifier comes from the current sample. phyupd needs
  // LIMIT+1 samples, so its current sample must also be waiting.
  dfi_req_timeout #(.LIMIT(TLP_RESP)) u_lp_ctrl_to (
    .clock   (clock),
    .reset   (reset),
    .cond    (lp_ctrl_wait),
    .expired (lp_ctrl_exp)
  );

  dfi_req_timeout #(.LIMIT(TLP_RESP)) u_lp_data_to (
    .clock   (clock),
    .reset   (reset),
    .cond    (lp_data_wait),
    .expired (lp_data_exp)
  );

  dfi_req_timeout #(.LIMIT(TPHYUPD_RESP)) u_phyupd_to (
    .clock   (clock),
    .reset   (reset),
    .cond    (phyupd_wait),
    .expired (phyupd_exp)
  );

  assign busy = addr_busy(dfi.address, ACTIVE_CODE);

  assign forbidden = (dfi.phyupd_ack & dfi.phymstr_ack)
                   | (dfi.init_start & dfi.phyupd_ack)
                   | (dfi.ctrlupd_req & dfi.phyupd_ack)
                   | (dfi.init_start & dfi.phymstr_ack)
                   | (dfi.init_start & dfi.ctrlupd_req)
                   | (dfi.init_start & dfi.lp_ctrl_req)
                   | (dfi.init_start & dfi.lp_data_req);

  always_comb begin
    lp_ctrl_ack_d = dfi.lp_ctrl_ack;
    lp_data_ack_d = dfi.lp_data_ack;
    phyupd_req_d  = dfi.phyupd_req;

    pulse_d = '0;
    pulse_d[LP_CTRL_TO]      = lp_ctrl_exp & dfi.lp_ctrl_req;
    pulse_d[LP_DATA_TO]      = lp_data_exp & dfi.lp_data_req;
    pulse_d[LP_CTRL_ACKDROP] = lp_ctrl_ack_q & ~dfi.lp_ctrl_ack & dfi.lp_ctrl_req;
    pulse_d[LP_DATA_ACKDROP] = lp_data_ack_q & ~dfi.lp_data_ack & dfi.lp_data_req;
    pulse_d[PHYUPD_TO]       = phyupd_exp & phyupd_wait;
    pulse_d[PHYUPD_REREQ]    = ~phyupd_req_q & dfi.phyupd_req & dfi.phyupd_ack;
    pulse_d[PHYUPD_ACKHOLD]  = ~phyupd_req_q & dfi.phyupd_ack;
    pulse_d[FORBIDDEN]       = forbidden;
    pulse_d[PHYUPD_NOTIDLE]  = dfi.phyupd_ack &
                               (dfi.lp_ctrl_req | dfi.lp_data_req |
                                dfi.phymstr_req | dfi.ctrlupd_req | busy);
    pulse_d[CTRLUPD_NOTIDLE] = dfi.ctrlupd_ack &
                               (dfi.lp_ctrl_req | dfi.lp_data_req |
                                dfi.phymstr_req | dfi.phyupd_req | busy);
    pulse_d[LPDATA_BUSY]     = dfi.lp_data_req & ((|dfi.wrdata_en) | (|dfi.rddata_en));
    pulse_d[LPCTRL_BUSY]     = dfi.lp_ctrl_req & busy;

    // Accumulate the pulse being registered this edge so sticky and count
    // rise together with err_pulse; a clear drops that cycle's contribution.
    sticky_d = sticky_q | pulse_d;
    count_d  = count_q;
    if ((|pulse_d) && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
    if (err_clr) begin
      sticky_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lp_ctrl_ack_q <= 1'b0;
      lp_data_ack_q <= 1'b0;
      phyupd_req_q  <= 1'b0;
      pulse_q       <= '0;
      sticky_q      <= '0;
      count_q       <= '0;
    end else begin
      lp_ctrl_ack_q <= lp_ctrl_ack_d;
      lp_data_ack_q <= lp_data_ack_d;
      phyupd_req_q  <= phyupd_req_d;
      pulse_q       <= pulse_d;
      sticky_q      <= sticky_d;
      count_q       <= count_d;
    end
  end

  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign err_any    = |pulse_q;
  assign err_count  = count_q;

`ifdef DFI_MODPORT_SVA_EN
  a_lp_ctrl_to: assert property (@(posedge clock) disable iff (!reset)
    not ((dfi.lp_ctrl_req && !dfi.lp_ctrl_ack) [*TLP_RESP] ##1 dfi.lp_ctrl_req))
    else $error("LP_CTRL_TO: lp_ctrl_req unacknowledged too long");
  a_lp_data_to: assert property (@(posedge clock) disable iff (!reset)
    not ((dfi.lp_data_req && !dfi.lp_data_ack) [*TLP_RESP] ##1 dfi.lp_data_req))
    else $error("LP_DATA_TO: lp_data_req unacknowledged too long");
  a_lp_ctrl_ackdrop: assert property (@(posedge clock) disable iff (!reset)
    !($fell(dfi.lp_ctrl_ack) && dfi.lp_ctrl_req))
    else $error("LP_CTRL_ACKDROP: lp_ctrl_ack fell while lp_ctrl_req high");
  a_lp_data_ackdrop: assert property (@(posedge clock) disable iff (!reset)
    !($fell(dfi.lp_data_ack) && dfi.lp_data_req))
    else $error("LP_DATA_ACKDROP: lp_data_ack fell while lp_data_req high");
  a_phyupd_to: assert property (@(posedge clock) disable iff (!reset)
    not ((dfi.phyupd_req && !dfi.phyupd_ack) [*TPHYUPD_RESP+1]))
    else $error("PHYUPD_TO: phyupd_ack late");
  a_phyupd_rereq: assert property (@(posedge clock) disable iff (!reset)
    !($rose(dfi.phyupd_req) && dfi.phyupd_ack))
    else $error("PHYUPD_REREQ: phyupd_req rose while phyupd_ack high");
  a_phyupd_ackhold: assert property (@(posedge clock) disable iff (!reset)
    !(!$past(dfi.phyupd_req) && dfi.phyupd_ack))
    else $error("PHYUPD_ACKHOLD: phyupd_ack high after phyupd_req low");
  a_forbidden: assert property (@(posedge clock) disable iff (!reset)
    !forbidden)
    else $error("FORBIDDEN: mutually exclusive DFI signals both high");
  a_phyupd_notidle: assert property (@(posedge clock) disable iff (!reset)
    !(dfi.phyupd_ack && (dfi.lp_ctrl_req || dfi.lp_data_req || dfi.phymstr_req ||
                         dfi.ctrlupd_req || busy)))
    else $error("PHYUPD_NOTIDLE: interface busy during phyupd_ack");
  a_ctrlupd_notidle: assert property (@(posedge clock) disable iff (!reset)
    !(dfi.ctrlupd_ack && (dfi.lp_ctrl_req || dfi.lp_data_req || dfi.phymstr_req ||
                          dfi.phyupd_req || busy)))
    else $error("CTRLUPD_NOTIDLE: interface busy during ctrlupd_ack");
  a_lpdata_busy: assert property (@(posedge clock) disable iff (!reset)
    !(dfi.lp_data_req && ((|dfi.wrdata_en) || (|dfi.rddata_en))))
    else $error("LPDATA_BUSY: data enables active during lp_data_req");
  a_lpctrl_busy: assert property (@(posedge clock) disable iff (!reset)
    !(dfi.lp_ctrl_req && busy))
    else $error("LPCTRL_BUSY: active address during lp_ctrl_req");

  a_x_update: assert property (@(posedge clock) disable iff (!reset)
    !$isunknown({dfi.ctrlupd_req, dfi.ctrlupd_ack, dfi.phyupd_req, dfi.phyupd_ack}))
    else $error("X on update handshake");
  a_x_phymstr: assert property (@(posedge clock) disable iff (!reset)
    !$isunknown({dfi.phymstr_req, dfi.phymstr_ack}))
    else $error("X on phymstr handshake");
  a_x_lp: assert property (@(posedge clock) disable iff (!reset)
    !$isunknown({dfi.lp_ctrl_req, dfi.lp_ctrl_ack, dfi.lp_data_req, dfi.lp_data_ack}))
    else $error("X on low-power handshake");
  a_x_init: assert property (@(posedge clock) disable iff (!reset)
    !$isunknown({dfi.init_start, err_clr}))
    else $error("X on init_start/err_clr");
  a_x_cmd: assert property (@(posedge clock) disable iff (!reset)
    !$isunknown({dfi.address, dfi.wrdata_en, dfi.rddata_en}))
    else $error("X on address/data enables");
`endif

endmodule

// File: tb/tb_dfi_modport.sv
module tb_dfi_modport;
  import dfi_modport_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        err_clr = 1'b0;
  logic [11:0] err_pulse;
  logic [11:0] err_sticky;
  logic        err_any;
  logic [15:0] err_count;

  dfi_modport_if dfi ();

  dfi_modport #(
    .TLP_RESP     (8),
    .TPHYUPD_RESP (16),
    .ACTIVE_CODE  (14'h0001),
    .CNT_W        (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dfi        (dfi.slave),
    .err_clr    (err_clr),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_any    (err_any),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] pulse;
    logic [11:0] sticky;
    logic [15:0] count;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [11:0] m_sticky = '0;
  logic [15:0] m_count  = '0;

  function automatic logic [11:0] b(input rule_e r);
    return 12'd1 << r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_inputs();
    dfi.ctrlupd_req = 0; dfi.ctrlupd_ack = 0;
    dfi.phyupd_req  = 0; dfi.phyupd_ack  = 0;
    dfi.phymstr_req = 0; dfi.phymstr_ack = 0;
    dfi.lp_ctrl_req = 0; dfi.lp_ctrl_ack = 0;
    dfi.lp_data_req = 0; dfi.lp_data_ack = 0;
    dfi.init_start  = 0;
    dfi.address     = '0;
    dfi.wrdata_en   = '0;
    dfi.rddata_en   = '0;
  endtask

  // Current inputs are sampled at the next edge; push what that edge must show.
  task automatic tick(input logic [11:0] pulse);
    exp_t e;
    @(posedge clock);
    if (err_clr) begin
      m_sticky = '0;
      m_count  = '0;
    end else begin
      m_sticky = m_sticky | pulse;
      if (pulse != 12'd0 && m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end
    e.pulse  = pulse;
    e.sticky = m_sticky;
    e.count  = m_count;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(12'd0);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_pulse"},  {20'd0, err_pulse},  32'd0);
    cmp({tag, "_sticky"}, {20'd0, err_sticky}, 32'd0);
    cmp({tag, "_any"},    {31'd0, err_any},    32'd0);
    cmp({tag, "_count"},  {16'd0, err_count},  32'd0);
  endtask

  // Monitor: one scoreboard entry per sampled edge, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("err_pulse",  {20'd0, err_pulse},  {20'd0, e.pulse});
        cmp("err_any",    {31'd0, err_any},    {31'd0, |e.pulse});
        cmp("err_sticky", {20'd0, err_sticky}, {20'd0, e.sticky});
        cmp("err_count",  {16'd0, err_count},  {16'd0, e.count});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset_state");
    reset = 1'b1;
    idle(2);

    // lp_ctrl timeout: 8 waiting samples, still requesting on the 9th and 10th
    dfi.lp_ctrl_req = 1;
    idle(8);
    tick(b(LP_CTRL_TO));
    tick(b(LP_CTRL_TO));
    dfi.lp_ctrl_req = 0;
    tick(12'd0);
    // 8 waiting samples then drop on the 9th: clean
    dfi.lp_ctrl_req = 1;
    idle(8);
    dfi.lp_ctrl_req = 0;
    idle(2);

    // lp_ctrl ack drop while request held
    dfi.lp_ctrl_req = 1;
    tick(12'd0);
    dfi.lp_ctrl_ack = 1;
    tick(12'd0);
    dfi.lp_ctrl_ack = 0;
    tick(b(LP_CTRL_ACKDROP));
    tick(12'd0);
    dfi.lp_ctrl_req = 0;
    idle(3);
    err_clr = 1;
    tick(12'd0);
    err_clr = 0;
    tick(12'd0);

    // phyupd acked on the 16th sample: clean
    dfi.phyupd_req = 1;
    idle(15);
    dfi.phyupd_ack = 1;
    tick(12'd0);
    dfi.phyupd_req = 0;
    dfi.phyupd_ack = 0;
    idle(2);
    // no ack for 17 samples
    dfi.phyupd_req = 1;
    idle(16);
    tick(b(PHYUPD_TO));
    dfi.phyupd_req = 0;
    tick(12'd0);
    dfi.phyupd_ack = 1;
    tick(b(PHYUPD_ACKHOLD));
    dfi.phyupd_req = 1;
    tick(b(PHYUPD_REREQ) | b(PHYUPD_ACKHOLD));
    clear_inputs();
    tick(12'd0);

    // forbidden and idle requirements
    dfi.init_start = 1; dfi.ctrlupd_req = 1;
    tick(b(FORBIDDEN));
    clear_inputs();
    dfi.ctrlupd_ack = 1;
    tick(12'd0);
    dfi.phymstr_req = 1;
    tick(b(CTRLUPD_NOTIDLE));
    clear_inputs();
    dfi.phyupd_req = 1;
    tick(12'd0);
    dfi.phyupd_ack = 1;
    dfi.address = 56'h00_0000_1000_0000;
    tick(b(PHYUPD_NOTIDLE));
    dfi.address = '0;
    dfi.phymstr_ack = 1;
    tick(b(FORBIDDEN));
    clear_inputs();
    tick(12'd0);

    // data enables / address during low-power requests
    dfi.lp_data_req = 1; dfi.rddata_en = 4'b0100;
    tick(b(LPDATA_BUSY));
    dfi.rddata_en = 4'b0000; dfi.wrdata_en = 4'b0001; dfi.init_start = 1;
    tick(b(FORBIDDEN) | b(LPDATA_BUSY));
    clear_inputs();
    tick(12'd0);
    dfi.lp_ctrl_req = 1; dfi.address = 56'h00_0000_0000_0001;
    tick(b(LPCTRL_BUSY));
    dfi.address = 56'h00_0800_0000_0000;
    tick(12'd0);
    clear_inputs();
    tick(12'd0);

    // lp_data ack drop and timeout
    dfi.lp_data_req = 1; dfi.lp_data_ack = 1;
    tick(12'd0);
    dfi.lp_data_ack = 0;
    tick(b(LP_DATA_ACKDROP));
    clear_inputs();
    tick(12'd0);
    dfi.lp_data_req = 1;
    idle(8);
    tick(b(LP_DATA_TO));
    clear_inputs();
    tick(12'd0);

    // clear coincident with a violation: pulse shown, not accumulated
    err_clr = 1; dfi.init_start = 1; dfi.lp_ctrl_req = 1;
    tick(b(FORBIDDEN));
    err_clr = 0;
    clear_inputs();
    tick(12'd0);
    dfi.init_start = 1; dfi.ctrlupd_req = 1;
    tick(b(FORBIDDEN));
    clear_inputs();
    tick(12'd0);

    // reset in the middle of an lp_ctrl wait window
    dfi.lp_ctrl_req = 1;
    idle(5);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_zero("reset_async");
    m_sticky = '0;
    m_count  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    idle(8);
    tick(b(LP_CTRL_TO));
    clear_inputs();
    tick(12'd0);

    @(negedge clock);
    #1;
    cmp("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dfi_modport.md
Name: dfi_modport

Overview:
- Synthesizable DFI control-channel protocol checker; taps the DFI monitor view (all inputs, never drives DFI).
- Sits beside the MC–PHY DFI boundary.
- Detects handshake, timeout, forbidden-state and idle-requirement violations on update, PHY-master, low-power and init signals.
- Reports violations as per-rule pulse and sticky flags plus a saturating violation counter.

Parameters:
- TLP_RESP, 8: max cycles lp_*_req may stay high without ack.
- TPHYUPD_RESP, 16: max cycles from phyupd_req to phyupd_ack.
- ACTIVE_CODE, 14'h0001: address phase value that marks a phase non-idle.
- CNT_W, 16: width of err_count.

Ports:
- clock  in  1  sampling clock, posedge.
- reset  in  1  asynchronous, active-low reset.
- ctrlupd_req, ctrlupd_ack  in  1 each.
- phyupd_req, phyupd_ack  in  1 each.
- phymstr_req, phymstr_ack  in  1 each.
- lp_ctrl_req, lp_ctrl_ack, lp_data_req, lp_data_ack  in  1 each.
- init_start  in  1.
- address  in  56  four 14-bit phases, phase p at [14p+13:14p].
- wrdata_en  in  4  one bit per phase.
- rddata_en  in  4  one bit per phase.
- err_clr  in  1  synchronous clear of sticky flags and counter.
- err_pulse  out  12  per-rule violation, high one cycle.
- err_sticky  out  12  accumulated err_pulse.
- err_any  out  1  OR of err_pulse.
- err_count  out  CNT_W  saturating count of cycles with err_any.

Behaviour:
- Reset (reset=0, async): all outputs 0, all history registers 0, all counters 0. After reset, edge detection compares against prev=0.
- Sampling: inputs sampled at each posedge k. err_pulse at edge k reflects samples at k and registered history from k-1. Latency is 1 clock from the offending sample to the visible flag.
- addr_busy = any phase address == ACTIVE_CODE.
- Rule bits:
  - 0 LP_CTRL_TO: lp_ctrl_req&~lp_ctrl_ack held TLP_RESP consecutive samples, and lp_ctrl_req still 1 at the next sample. Repeats each cycle req stays high.
  - 1 LP_DATA_TO: same as bit 0 for lp_data.
  - 2 LP_CTRL_ACKDROP: lp_ctrl_ack falls (prev 1, now 0) while lp_ctrl_req=1.
  - 3 LP_DATA_ACKDROP: same as bit 2 for lp_data.
  - 4 PHYUPD_TO: phyupd_req&~phyupd_ack for TPHYUPD_RESP+1 consecutive samples. Repeats while the condition persists.
  - 5 PHYUPD_REREQ: phyupd_req rises while phyupd_ack=1.
  - 6 PHYUPD_ACKHOLD: phyupd_req=0 at k-1 and phyupd_ack=1 at k.
  - 7 FORBIDDEN: any of these pairs both 1:
    - phyupd_ack&phymstr_ack
    - init_start&phyupd_ack
    - ctrlupd_req&phyupd_ack
    - init_start&phymstr_ack
    - init_start&ctrlupd_req
    - init_start&lp_ctrl_req
    - init_start&lp_data_req
  - 8 PHYUPD_NOTIDLE: phyupd_ack & (lp_ctrl_req|lp_data_req|phymstr_req|ctrlupd_req|addr_busy).
  - 9 CTRLUPD_NOTIDLE: ctrlupd_ack & (lp_ctrl_req|lp_data_req|phymstr_req|phyupd_req|addr_busy).
  - 10 LPDATA_BUSY: lp_data_req & (|wrdata_en | |rddata_en).
  - 11 LPCTRL_BUSY: lp_ctrl_req & addr_busy.
- Timeout counters: clear to 0 whenever their condition is false; saturate at their limit; never wrap.
- Sticky/counter update: err_sticky |= err_pulse. err_count increments when err_any=1, saturating at all-ones.
- err_clr=1: sticky and count load 0 that cycle. A same-cycle err_pulse is still shown on err_pulse but is not accumulated. Pulses are not suppressed by err_clr.
- Simultaneous violations: all applicable bits set in the same cycle; err_count still increments by 1.
- ctrlupd_ack without ctrlupd_req is legal (not flagged).

Optional Feature:
- DFI_MODPORT_SVA_EN defined: adds concurrent assertions, one per rule (error message names the rule), plus $isunknown checks on every input group. Excluded from synthesis.
- Undefined: pure RTL flags only. Flag behaviour is identical in both cases.

Decomposition:
- Package dfi_modport_pkg:
  - rule index enum (LP_CTRL_TO..LPCTRL_BUSY)
  - ERR_W=12
  - default TLP_RESP / TPHYUPD_RESP constants
  - NUM_PHASES=4, ADDR_W=14
- Sub-module dfi_req_timeout: saturating consecutive-condition counter with LIMIT parameter and expired output. Instantiated for lp_ctrl, lp_data and phyupd.

Test Plan:
- lp_ctrl_req=1, ack=0 for 8 cycles, req still 1 on cycle 9 -> err_pulse[0]=1 one clock later; req drop on cycle 9 -> no error.
- phyupd_req=1, ack arrives at cycle 16 -> clean; no ack through 17 samples -> err_pulse[4]=1; then req=0 while ack=1 next -> err_pulse[6]=1.
- lp_ctrl_ack falls while lp_ctrl_req=1 -> err_pulse[2]=1, err_sticky[2] stays 1 until err_clr.
- init_start=1 with ctrlupd_req=1 -> err_pulse[7]=1; phyupd_ack=1 with address phase 2=14'h0001 -> err_pulse[8]=1.
- lp_data_req=1 with rddata_en=4'b0100 -> err_pulse[10]=1; bits 7 and 10 in the same cycle -> err_count +1 only.
- Assert reset mid-timeout at count 5 -> counters 0, outputs 0; a fresh 8-cycle req window needed to flag.
